rv_mc_sequencer: RTL and testbench

- Parametrised multicycle sequencer for the RISC-V core. Owns the PC, the instruction register, the memory request/acknowledge handshake, MMIO store routing, register writeback selection, breakpoint/single-step control and a retired-instruction counter.
- Replaces fixed wait-state sequencing with a variable-latency handshake and a bounded timeout.
- Sits between the instruction decoder / ALU / register file and the byte-addressable memory and ASCII/VGA controller.

---
 rtl/rv_mc_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_rv_mc_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mc_sequencer.sv
// Multicycle RISC-V sequencer: PC, IR, variable-latency memory handshake with timeout,
// MMIO store routing, writeback selection, breakpoint/single-step and retired counter.
module rv_mc_sequencer #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter logic [WORD_SIZE-1:0] MMIO_BASE = WORD_SIZE'(32'h00020000),
  parameter int                   TIMEOUT   = 16,
  parameter int                   CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic                 break_en,
  input  logic [WORD_SIZE-1:0] break_addr,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [1:0]           mem_we,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic                 mem_err,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] instr,
  input  logic                 decode_error,
  input  logic                 jump,
  input  logic                 jal_or_jalr,
  input  logic                 branch,
  input  logic                 branch_taken,
  input  logic                 mem_to_reg,
  input  logic [1:0]           mem_write_size,
  input  logic [2:0]           reg_load_size,
  input  logic [WORD_SIZE-1:0] imm,
  input  logic [WORD_SIZE-1:0] rv1,
  input  logic [WORD_SIZE-1:0] rv2,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 reg_we,
  output logic [WORD_SIZE-1:0] reg_wdata,
  output logic                 mmio_we,
  output logic [12:0]          mmio_addr,
  output logic [WORD_SIZE-1:0] mmio_data,
  output logic [3:0]           state,
  output logic [1:0]           err_code,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH      = 4'd1,
    S_WAIT_FETCH = 4'd2,
    S_EXECUTE    = 4'd3,
    S_MEM        = 4'd4,
    S_WRITEBACK  = 4'd5,
    S_PAUSE      = 4'd6,
    S_HALT       = 4'd7,
    S_ERROR      = 4'd15
  } state_t;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ERR_DEC = 2'd1;
  localparam logic [1:0] ERR_MEM = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  state_t               cur_st, nxt_st;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [WORD_SIZE-1:0] ld_data;
  logic                 resume;
  logic                 trap, timed_out, is_halt, is_store, is_mmio, go_mem;
  logic [WORD_SIZE-1:0] ld_ext, wb_data, pc_next, jalr_tgt, pc_plus4;

  assign state     = cur_st;
  // resume masks the breakpoint for exactly the fetch that follows a step out of PAUSE
  assign trap      = break_en && (pc == break_addr) && !resume;
  assign timed_out = !mem_ack && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign is_halt   = (instr[6:0] == 7'h7F);
  assign is_store  = !mem_to_reg && (mem_write_size != 2'd0);
  assign is_mmio   = is_store && (alu_out >= MMIO_BASE);
  assign go_mem    = mem_to_reg || (is_store && !is_mmio);
  assign pc_plus4  = pc + WORD_SIZE'(4);
  assign jalr_tgt  = rv1 + imm;

  always_comb begin
    ld_ext = ld_data;
    case (reg_load_size)
      3'b000:  ld_ext = {{(WORD_SIZE-8){ld_data[7]}}, ld_data[7:0]};
      3'b001:  ld_ext = {{(WORD_SIZE-16){ld_data[15]}}, ld_data[15:0]};
      3'b100:  ld_ext = {{(WORD_SIZE-8){1'b0}}, ld_data[7:0]};
      3'b101:  ld_ext = {{(WORD_SIZE-16){1'b0}}, ld_data[15:0]};
      default: ld_ext = ld_data;
    endcase
  end

  always_comb begin
    wb_data = alu_out;
    if (jump)            wb_data = pc_plus4;
    else if (mem_to_reg) wb_data = ld_ext;

    pc_next = pc_plus4;
    if (jump && jal_or_jalr)          pc_next = pc + imm;
    else if (jump)                    pc_next = {jalr_tgt[WORD_SIZE-1:1], 1'b0};
    else if (branch && branch_taken)  pc_next = pc + imm;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_st <= S_IDLE;
    else      cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      S_IDLE:       if (start) nxt_st = S_FETCH;
      S_FETCH:      nxt_st = trap ? S_PAUSE : S_WAIT_FETCH;
      S_WAIT_FETCH: begin
        if (mem_ack)        nxt_st = mem_err ? S_ERROR : S_EXECUTE;
        else if (timed_out) nxt_st = S_ERROR;
      end
      S_EXECUTE: begin
        if (is_halt)           nxt_st = S_HALT;
        else if (decode_error) nxt_st = S_ERROR;
        else if (go_mem)       nxt_st = S_MEM;
        else                   nxt_st = S_WRITEBACK;
      end
      S_MEM: begin
        if (mem_ack)        nxt_st = mem_err ? S_ERROR : S_WRITEBACK;
        else if (timed_out) nxt_st = S_ERROR;
      end
      S_WRITEBACK:  nxt_st = step_mode ? S_PAUSE : S_FETCH;
      S_PAUSE:      if (step) nxt_st = S_FETCH;
      default:      nxt_st = cur_st;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      instr     <= '0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
      mmio_we   <= 1'b0;
      mmio_addr <= '0;
      mmio_data <= '0;
      retired   <= '0;
      err_code  <= 2'd0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 2'd0;
      mem_wdata <= '0;
      ld_data   <= '0;
      wait_cnt  <= '0;
      resume    <= 1'b0;
    end else begin
      reg_we  <= 1'b0;
      mmio_we <= 1'b0;
      case (cur_st)
        S_FETCH: begin
          resume <= 1'b0;
          if (!trap) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
            mem_we   <= 2'd0;
            wait_cnt <= '0;
          end
        end
        S_WAIT_FETCH, S_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 2'd0;
            if (mem_err)                 err_code <= ERR_MEM;
            else if (cur_st == S_MEM)    ld_data  <= mem_rdata;
            else                         instr    <= mem_rdata;
          end else if (timed_out) begin
            mem_req  <= 1'b0;
            mem_we   <= 2'd0;
            err_code <= ERR_TMO;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_EXECUTE: begin
          if (!is_halt) begin
            if (decode_error) begin
              err_code <= ERR_DEC;
            end else if (go_mem) begin
              mem_req   <= 1'b1;
              mem_addr  <= alu_out;
              mem_we    <= mem_to_reg ? 2'd0 : mem_write_size;
              mem_wdata <= rv2;
              wait_cnt  <= '0;
            end else if (is_mmio) begin
              mmio_we   <= 1'b1;
              mmio_addr <= alu_out[12:0];
              mmio_data <= rv2;
            end
          end
        end
        S_WRITEBACK: begin
          reg_we    <= !is_store && !branch;
          reg_wdata <= wb_data;
          pc        <= pc_next;
          retired   <= retired + CNT_W'(1);
        end
        S_PAUSE: if (step) resume <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Bench for rv_mc_sequencer: table of instructions with a memory responder and a retire scoreboard,
// plus hand sequences for breakpoint/step, timeout, faults, halt and asynchronous reset.
module tb_rv_mc_sequencer;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start, step_mode, step, break_en;
  logic [W-1:0]  break_addr;
  logic          mem_req;
  logic [W-1:0]  mem_addr;
  logic [1:0]    mem_we;
  logic [W-1:0]  mem_wdata;
  logic          mem_ack, mem_err;
  logic [W-1:0]  mem_rdata, instr;
  logic          decode_error, jump, jal_or_jalr, branch, branch_taken, mem_to_reg;
  logic [1:0]    mem_write_size;
  logic [2:0]    reg_load_size;
  logic [W-1:0]  imm, rv1, rv2, alu_out, pc;
  logic          reg_we;
  logic [W-1:0]  reg_wdata;
  logic          mmio_we;
  logic [12:0]   mmio_addr;
  logic [W-1:0]  mmio_data;
  logic [3:0]    state;
  logic [1:0]    err_code;
  logic [31:0]   retired;

  always #5 clk = ~clk;

  rv_mc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .break_en(break_en), .break_addr(break_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata), .instr(instr),
    .decode_error(decode_error), .jump(jump), .jal_or_jalr(jal_or_jalr), .branch(branch),
    .branch_taken(branch_taken), .mem_to_reg(mem_to_reg), .mem_write_size(mem_write_size),
    .reg_load_size(reg_load_size), .imm(imm), .rv1(rv1), .rv2(rv2), .alu_out(alu_out),
    .pc(pc), .reg_we(reg_we), .reg_wdata(reg_wdata), .mmio_we(mmio_we),
    .mmio_addr(mmio_addr), .mmio_data(mmio_data), .state(state), .err_code(err_code),
    .retired(retired)
  );

  typedef struct {
    logic [31:0] instr_w;
    logic        jump, jal, br, taken, m2r;
    logic [1:0]  msize;
    logic [2:0]  lsize;
    logic [31:0] imm, rv1, rv2, alu, ldata;
    int          lat;
    int          mem_acc;
    logic        e_we;
    logic [31:0] e_wdata, e_pc;
    logic        e_mmio;
  } vec_t;

  typedef struct { logic we; logic [31:0] wdata, pc, ret; } exp_t;
  typedef struct { logic [12:0] a; logic [31:0] d; } mm_t;

  vec_t tbl[$];
  exp_t sbq[$];
  mm_t  mq[$];

  int total = 0, bad = 0;
  int req_cycles = 0, we_cnt = 0, mmio_cnt = 0;
  int lat_fetch = 1, lat_mem = 1, n_ret = 0;
  logic err_inject = 1'b0;
  logic [31:0] fetch_word = '0, load_word = '0;
  logic [31:0] cur_pc = '0, exp_fetch_pc = '0, exp_maddr = '0, exp_mwdata = '0;
  logic [1:0]  exp_mwe = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] iw, input logic j, input logic jl, input logic b,
                              input logic bt, input logic m2r, input logic [1:0] ms,
                              input logic [2:0] ls, input logic [31:0] im, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] al, input logic [31:0] ld,
                              input int lat, input int macc, input logic ewe,
                              input logic [31:0] ewd, input logic [31:0] epc, input logic emm);
    vec_t v;
    v.instr_w = iw; v.jump = j; v.jal = jl; v.br = b; v.taken = bt; v.m2r = m2r;
    v.msize = ms; v.lsize = ls; v.imm = im; v.rv1 = r1; v.rv2 = r2; v.alu = al; v.ldata = ld;
    v.lat = lat; v.mem_acc = macc; v.e_we = ewe; v.e_wdata = ewd; v.e_pc = epc; v.e_mmio = emm;
    return v;
  endfunction

  function automatic vec_t alu_vec(input logic [31:0] al, input int lat, input logic [31:0] epc);
    return mk(32'h00500093, 0, 0, 0, 0, 0, 2'd0, 3'd0, 32'h5, 32'h0, 32'h0, al, 32'h0,
              lat, 0, 1'b1, al, epc, 1'b0);
  endfunction

  // Memory responder: acks after a programmed number of request cycles (0 = never)
  initial begin
    int wcnt, lt;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req && (state == 4'd2 || state == 4'd4)) begin
        req_cycles++;
        wcnt++;
        lt = (state == 4'd2) ? lat_fetch : lat_mem;
        if (lt != 0 && wcnt == lt) begin
          mem_ack   = 1'b1;
          mem_err   = err_inject;
          mem_rdata = (state == 4'd2) ? fetch_word : load_word;
          if (state == 4'd2) begin
            chk("fetch_addr", mem_addr, exp_fetch_pc);
            chk("fetch_we", {30'd0, mem_we}, 32'd0);
          end else begin
            chk("mem_addr", mem_addr, exp_maddr);
            chk("mem_we", {30'd0, mem_we}, {30'd0, exp_mwe});
            chk("mem_wdata", mem_wdata, exp_mwdata);
          end
        end else begin
          mem_ack = 1'b0; mem_err = 1'b0;
        end
      end else begin
        wcnt = 0; mem_ack = 1'b0; mem_err = 1'b0;
      end
    end
  end

  // Retire / MMIO monitor: pops the scoreboard whenever the retired count advances
  initial begin
    logic [31:0] prev_ret;
    exp_t e;
    mm_t  m;
    prev_ret = '0;
    forever begin
      @(negedge clk);
      if (reg_we) we_cnt++;
      if (mmio_we) begin
        mmio_cnt++;
        if (mq.size() == 0) begin
          total++; bad++;
          $display("FAIL mmio_unexpected: addr %h data %h with nothing expected", mmio_addr, mmio_data);
        end else begin
          m = mq.pop_front();
          chk("mmio_addr", {19'd0, mmio_addr}, {19'd0, m.a});
          chk("mmio_data", mmio_data, m.d);
        end
      end
      if (rst && retired == prev_ret + 32'd1) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL retire_unexpected: retired=%0d with nothing expected", retired);
        end else begin
          e = sbq.pop_front();
          chk("retire_pc", pc, e.pc);
          chk("retired", retired, e.ret);
          chk("reg_we", {31'd0, reg_we}, {31'd0, e.we});
          if (e.we) chk("reg_wdata", reg_wdata, e.wdata);
        end
      end
      prev_ret = retired;
    end
  end

  task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {28'd0, state}, {28'd0, s});
  endtask

  task automatic run_vec(input vec_t v, input bit do_step);
    exp_t e;
    mm_t  m;
    int   n = 0;
    jump = v.jump; jal_or_jalr = v.jal; branch = v.br; branch_taken = v.taken;
    mem_to_reg = v.m2r; mem_write_size = v.msize; reg_load_size = v.lsize;
    imm = v.imm; rv1 = v.rv1; rv2 = v.rv2; alu_out = v.alu;
    fetch_word = v.instr_w; load_word = v.ldata; lat_fetch = v.lat; lat_mem = v.lat;
    exp_fetch_pc = cur_pc; exp_maddr = v.alu; exp_mwdata = v.rv2;
    exp_mwe = v.m2r ? 2'd0 : v.msize;
    n_ret++;
    e.we = v.e_we; e.wdata = v.e_wdata; e.pc = v.e_pc; e.ret = 32'(n_ret);
    sbq.push_back(e);
    if (v.e_mmio) begin
      m.a = v.alu[12:0]; m.d = v.rv2;
      mq.push_back(m);
    end
    req_cycles = 0;
    if (do_step) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
    while (retired != 32'(n_ret) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (retired != 32'(n_ret)) begin
      total++; bad++;
      $display("FAIL retire_timeout: retired=%0d expected %0d", retired, n_ret);
    end
    chk("req_cycles", 32'(req_cycles), 32'(v.lat * (1 + v.mem_acc)));
    cur_pc = v.e_pc;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; step = 1'b0; step_mode = 1'b0; break_en = 1'b0; break_addr = '0;
    decode_error = 1'b0; jump = 1'b0; jal_or_jalr = 1'b0; branch = 1'b0; branch_taken = 1'b0;
    mem_to_reg = 1'b0; mem_write_size = 2'd0; reg_load_size = 3'd0;
    imm = '0; rv1 = '0; rv2 = '0; alu_out = '0;
    err_inject = 1'b0; lat_fetch = 1; lat_mem = 1;
    cur_pc = '0; exp_fetch_pc = '0; n_ret = 0;
    sbq.delete(); mq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // instr, j, jal, br, taken, m2r, msize, lsize, imm, rv1, rv2, alu, ldata, lat, macc, we, wdata, pc, mmio
    tbl.push_back(alu_vec(32'h5, 3, 32'h4));
    tbl.push_back(mk(32'h00000003, 0,0,0,0,1, 2'd0, 3'b000, 0, 0, 0, 32'h100, 32'hABCD12F0, 1, 1, 1, 32'hFFFFFFF0, 32'h8, 0));
    tbl.push_back(mk(32'h00004003, 0,0,0,0,1, 2'd0, 3'b100, 0, 0, 0, 32'h101, 32'hABCD12F0, 2, 1, 1, 32'h000000F0, 32'hC, 0));
    tbl.push_back(mk(32'h00001003, 0,0,0,0,1, 2'd0, 3'b001, 0, 0, 0, 32'h102, 32'h55558001, 1, 1, 1, 32'hFFFF8001, 32'h10, 0));
    tbl.push_back(mk(32'h00005003, 0,0,0,0,1, 2'd0, 3'b101, 0, 0, 0, 32'h104, 32'h55558001, 4, 1, 1, 32'h00008001, 32'h14, 0));
    tbl.push_back(mk(32'h00002003, 0,0,0,0,1, 2'd0, 3'b010, 0, 0, 0, 32'h108, 32'hDEADBEEF, 1, 1, 1, 32'hDEADBEEF, 32'h18, 0));
    tbl.push_back(mk(32'h00002023, 0,0,0,0,0, 2'd3, 3'b010, 0, 0, 32'h1234, 32'h200, 0, 2, 1, 0, 0, 32'h1C, 0));
    tbl.push_back(mk(32'h00002023, 0,0,0,0,0, 2'd3, 3'b010, 0, 0, 32'h41, 32'h00020010, 0, 1, 0, 0, 0, 32'h20, 1));
    tbl.push_back(mk(32'h00000063, 0,0,1,1,0, 2'd0, 3'd0, 32'h40, 0, 0, 32'h1, 0, 1, 0, 0, 0, 32'h60, 0));
    tbl.push_back(mk(32'h00000063, 0,0,1,0,0, 2'd0, 3'd0, 32'h40, 0, 0, 32'h0, 0, 2, 0, 0, 0, 32'h64, 0));
    tbl.push_back(mk(32'h0000006F, 1,1,0,0,0, 2'd0, 3'd0, 32'h100, 0, 0, 32'h0, 0, 1, 0, 1, 32'h68, 32'h164, 0));
    tbl.push_back(mk(32'h00000067, 1,0,0,0,0, 2'd0, 3'd0, 32'h4, 32'h101, 0, 32'h0, 0, 3, 0, 1, 32'h168, 32'h104, 0));
    tbl.push_back(mk(32'h0000006F, 1,1,0,0,0, 2'd0, 3'd0, 32'hFFFFFF00, 0, 0, 32'h0, 0, 1, 0, 1, 32'h108, 32'h4, 0));
    tbl.push_back(mk(32'h00000033, 0,0,0,0,0, 2'd0, 3'd0, 0, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 1, 32'hFFFFFFFF, 32'h8, 0));

    // Reset state
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_err", {30'd0, err_code}, 32'd0);
    chk("rst_ctrl", {28'd0, mem_req, reg_we, mmio_we, 1'b0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven instruction stream
    we_cnt = 0; mmio_cnt = 0;
    start = 1'b1;
    foreach (tbl[i]) run_vec(tbl[i], 1'b0);
    chk("reg_we_pulses", 32'(we_cnt), 32'd10);
    chk("mmio_pulses", 32'(mmio_cnt), 32'd1);
    chk("last_instr", instr, 32'h00000033);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    // Breakpoint, stray step, single step
    do_reset();
    break_en = 1'b1; break_addr = 32'h8;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    start = 1'b1;
    run_vec(alu_vec(32'h11, 2, 32'h4), 1'b0);
    run_vec(alu_vec(32'h22, 1, 32'h8), 1'b0);
    wait_state(4'd6, 20, "brk_pause");
    req_cycles = 0;
    repeat (4) @(negedge clk);
    chk("brk_state", {28'd0, state}, 32'd6);
    chk("brk_pc", pc, 32'h8);
    chk("brk_nofetch", 32'(req_cycles), 32'd0);
    step_mode = 1'b1;
    run_vec(alu_vec(32'h33, 2, 32'hC), 1'b1);
    repeat (3) @(negedge clk);
    chk("stepmode_state", {28'd0, state}, 32'd6);
    chk("stepmode_pc", pc, 32'hC);
    step_mode = 1'b0;
    run_vec(alu_vec(32'h44, 1, 32'h10), 1'b1);

    // Fetch timeout
    do_reset();
    lat_fetch = 0; req_cycles = 0; start = 1'b1;
    wait_state(4'd15, 100, "tmo_state");
    chk("tmo_req_cycles", 32'(req_cycles), 32'd16);
    chk("tmo_err", {30'd0, err_code}, 32'd3);
    chk("tmo_req", {31'd0, mem_req}, 32'd0);

    // Fetch fault
    do_reset();
    err_inject = 1'b1; lat_fetch = 2; start = 1'b1;
    wait_state(4'd15, 50, "fault_state");
    chk("fault_err", {30'd0, err_code}, 32'd2);
    chk("fault_req", {31'd0, mem_req}, 32'd0);

    // Decode error
    do_reset();
    fetch_word = 32'h00500093; decode_error = 1'b1; start = 1'b1;
    wait_state(4'd15, 50, "dec_state");
    chk("dec_err", {30'd0, err_code}, 32'd1);

    // Halt opcode
    do_reset();
    fetch_word = 32'h0000007F; start = 1'b1;
    wait_state(4'd7, 50, "halt_state");
    repeat (3) @(negedge clk);
    chk("halt_hold", {28'd0, state}, 32'd7);
    chk("halt_pc", pc, 32'h0);
    chk("halt_retired", retired, 32'h0);
    chk("halt_instr", instr, 32'h0000007F);

    // Asynchronous reset in the middle of a load
    do_reset();
    start = 1'b1;
    run_vec(alu_vec(32'h7, 1, 32'h4), 1'b0);
    mem_to_reg = 1'b1; alu_out = 32'h300; rv2 = 32'h0; exp_maddr = 32'h300; exp_mwe = 2'd0;
    exp_fetch_pc = 32'h4; fetch_word = 32'h00002003; lat_fetch = 1; lat_mem = 0;
    wait_state(4'd4, 30, "mid_mem_state");
    repeat (2) @(negedge clk);
    chk("mid_mem_req", {31'd0, mem_req}, 32'd1);
    chk("mid_mem_addr", mem_addr, 32'h300);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_state", {28'd0, state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
